conv_frame_sched: RTL



---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_xy_counter.sv | 65 ++++++
 rtl/conv_frame_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and constants for the conv-unit frame scheduler:
//            scheduler state encoding, default IFM/kernel/pool geometry and
//            the derived conv-array / pooled-array dimensions.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Default frame geometry
  localparam int IFM_W_DEF = 14;
  localparam int K_DEF     = 3;
  localparam int POOL_DEF  = 2;

  // Derived array dimensions for the default geometry
  localparam int CW_DEF = IFM_W_DEF - K_DEF + 1;
  localparam int PW_DEF = CW_DEF / POOL_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_POOL   = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_e;

  // Side length of the valid-convolution output for an ifm_w input and k kernel
  function automatic int conv_out_w(input int ifm_w, input int k);
    return ifm_w - k + 1;
  endfunction

  // Counter width able to hold 0..n-1 (never less than one bit)
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_xy_counter.sv
`default_nettype none
// ============================================================================
// Module   : conv_xy_counter
// Purpose  : 2-D raster counter. Column advances on each enabled cycle and
//            wraps COLS-1 -> 0, carrying into the row; the row wraps
//            ROWS-1 -> 0 so the counter is back at (0,0) after a full sweep.
// Ports    : clk, rst_n (async, active-low)
//            en_i   - advance one position
//            row_o  - current row
//            col_o  - current column
//            last_o - current position is (ROWS-1, COLS-1)
// Revision : 1.0 - initial release
// ============================================================================
module conv_xy_counter
  import conv_pkg::*;
#(
  parameter  int ROWS = PW_DEF,
  parameter  int COLS = PW_DEF,
  localparam int RB   = cnt_bits(ROWS),
  localparam int CB   = cnt_bits(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [RB-1:0] row_o,
  output logic [CB-1:0] col_o,
  output logic          last_o
);

  logic [RB-1:0] row_q, row_d;
  logic [CB-1:0] col_q, col_d;
  logic          row_end, col_end;

  assign row_end = (row_q == RB'(ROWS - 1));
  assign col_end = (col_q == CB'(COLS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_end && col_end;

endmodule
`default_nettype wire

// File: rtl/conv_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_sched
// Purpose  : Frame-level scheduler for the single conv-unit datapath. Accepts
//            a raster IFM pixel stream, flags full KxK windows, generates the
//            conv-array write addresses, then sequences the pooled read-out.
//            Optional build macro CONV_SCHED_OVF_EN adds a sticky 'ovf'
//            output flagging pixels offered while in_ready is low.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready      - pixel handshake
//            win_valid                - conv window complete this cycle
//            wr_en, wr_row, wr_col    - conv-array write strobe and address
//            pool_rd_en, pool_row/col - pooled read request and address
//            out_valid                - pooled result valid
//            busy, done               - not idle / end-of-frame pulse
//            ovf (CONV_SCHED_OVF_EN)  - sticky dropped-pixel flag
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_sched
  import conv_pkg::*;
#(
  parameter  int IFM_W = IFM_W_DEF,
  parameter  int K     = K_DEF,
  parameter  int POOL  = POOL_DEF,
  localparam int CW    = conv_out_w(IFM_W, K),
  localparam int PW    = CW / POOL,
  localparam int CB    = $clog2(CW),
  localparam int PB    = $clog2(PW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          win_valid,
  output logic          wr_en,
  output logic [CB-1:0] wr_row,
  output logic [CB-1:0] wr_col,
  output logic          pool_rd_en,
  output logic [PB-1:0] pool_row,
  output logic [PB-1:0] pool_col,
  output logic          out_valid,
  output logic          busy,
  output logic          done
`ifdef CONV_SCHED_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int IB = cnt_bits(IFM_W);

  sched_state_e state_q, state_d;

  logic          accept;
  logic [IB-1:0] pix_row, pix_col;
  logic          pix_last;
  logic [CB-1:0] cw_row, cw_col;
  logic          cw_last;
  logic          pr_last;

  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pool_rd_en_q, pool_rd_en_d;
  logic          win_valid_q, win_valid_d;
  logic          wr_en_q, wr_last_q, out_valid_q;
  logic [CB-1:0] wr_row_q, wr_col_q;

  assign accept = in_valid && in_ready_q;

  // A window is complete once the accepted pixel sits at or beyond the
  // kernel's bottom-right corner; row-edge pixels (col < K-1) are skipped.
  assign win_valid_d = accept && (pix_row >= IB'(K - 1)) && (pix_col >= IB'(K - 1));

  // Pixel position of the next pixel to be accepted
  conv_xy_counter #(.ROWS(IFM_W), .COLS(IFM_W)) u_pix_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept),
    .row_o  (pix_row),
    .col_o  (pix_col),
    .last_o (pix_last)
  );

  // Conv-array write address; windows arrive in raster order, so a plain
  // counter stepped per window equals (r-(K-1), c-(K-1)).
  conv_xy_counter #(.ROWS(CW), .COLS(CW)) u_wr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (win_valid_q),
    .row_o  (cw_row),
    .col_o  (cw_col),
    .last_o (cw_last)
  );

  // Pooled read address; drives the output port directly and only moves
  // while a read is being issued, so it rests at (0,0) outside POOL.
  conv_xy_counter #(.ROWS(PW), .COLS(PW)) u_pool_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (pool_rd_en_q),
    .row_o  (pool_row),
    .col_o  (pool_col),
    .last_o (pr_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = pix_last ? ST_DRAIN : ST_STREAM;
      ST_STREAM: if (accept && pix_last) state_d = ST_DRAIN;
      // wr_last_q marks the cycle in which the final write is on the bus
      ST_DRAIN:  if (wr_last_q) state_d = ST_POOL;
      ST_POOL:   if (pr_last) state_d = ST_DONE;
      // in_ready is high in DONE, so a pixel offered here opens a new frame
      ST_DONE:   state_d = accept ? (pix_last ? ST_DRAIN : ST_STREAM) : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it
    in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_STREAM) || (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    pool_rd_en_d = (state_d == ST_POOL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pool_rd_en_q <= 1'b0;
      win_valid_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_last_q    <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pool_rd_en_q <= pool_rd_en_d;
      win_valid_q  <= win_valid_d;
      wr_en_q      <= win_valid_q;
      wr_last_q    <= win_valid_q && cw_last;
      if (win_valid_q) begin
        wr_row_q <= cw_row;
        wr_col_q <= cw_col;
      end
      out_valid_q  <= pool_rd_en_q;
    end
  end

`ifdef CONV_SCHED_OVF_EN
  logic ovf_q, ovf_d;
  logic viol;

  assign viol = in_valid && !in_ready_q;

  // Sticky; a violation in the DONE->IDLE cycle wins over the clear
  always_comb begin
    ovf_d = ovf_q;
    if (viol) begin
      ovf_d = 1'b1;
    end else if ((state_q == ST_DONE) && (state_d == ST_IDLE)) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready   = in_ready_q;
  assign win_valid  = win_valid_q;
  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign pool_rd_en = pool_rd_en_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire
